// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// No logic of its own.
// Also used by uart_rx, so keep the encodings stable.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE         = 3'd0,
        s_TX_START_BIT = 3'd1,
        s_TX_DATA_BITS = 3'd2,
        s_TX_STOP_BIT  = 3'd3,
        s_CLEANUP      = 3'd4
    } uart_state_t;

    // 100 MHz core clock at 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 10416;
    localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO holding bytes waiting for the UART transmitter.
// Latency: a write is visible on rd_vld/rd_dat the cycle after it is accepted.
// Backpressure: wr_rdy is registered and drops when full; a write while full is ignored.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    input  logic             rd_en,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(FIFO_DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_d;
    logic             rdy_q;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];

    assign wr_rdy   = rdy_q;
    assign wr_fire  = wr_vld & rdy_q;
    assign rd_vld   = (wr_ptr_q != rd_ptr_q);
    assign rd_fire  = rd_en & rd_vld;
    assign rd_dat   = mem[rd_ptr_q[AW-1:0]];
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_fire};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_fire};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // Ready reflects next-cycle occupancy so it can be a flop.
            rdy_q    <= ((wr_ptr_d - rd_ptr_d) != FULL_OCC);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop shifter.
// Latency: byte written to an empty FIFO with the FSM idle starts its start bit one cycle later.
// Backpressure: o_Tx_Ready low while FIFO full; writes then dropped and flagged on o_Tx_Ovf.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Ready,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Active,
    output logic       o_Tx_Done,
    output logic       o_Tx_Ovf
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t      state_q;
    uart_state_t      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_q;
    logic [2:0]       bit_d;
    logic [7:0]       shift_q;
    logic [7:0]       shift_d;
    logic             serial_q;
    logic             serial_d;
    logic             active_q;
    logic             active_d;
    logic             done_q;
    logic             done_d;
    logic             ovf_q;

    logic             fifo_rdy;
    logic             fifo_vld;
    logic [7:0]       fifo_dat;
    logic             pop;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk    (i_Clock),
        .rst_n  (i_Reset_n),
        .wr_vld (i_Tx_DV),
        .wr_dat (i_Tx_Byte),
        .wr_rdy (fifo_rdy),
        .rd_en  (pop),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_dat)
    );

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= s_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
            ovf_q    <= i_Tx_DV & ~fifo_rdy;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        active_d = active_q;
        done_d   = 1'b0;
        pop      = 1'b0;

        case (state_q)
            s_IDLE: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                bit_d    = '0;
                if (fifo_vld) begin
                    pop      = 1'b1;
                    shift_d  = fifo_dat;
                    serial_d = 1'b0;
                    active_d = 1'b1;
                    state_d  = s_TX_START_BIT;
                end
            end

            s_TX_START_BIT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    serial_d = shift_q[0];
                    state_d  = s_TX_DATA_BITS;
                end
            end

            // The shifter moves right so the next bit is always at [1].
            s_TX_DATA_BITS: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        serial_d = 1'b1;
                        state_d  = s_TX_STOP_BIT;
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        serial_d = shift_q[1];
                    end
                end
            end

            s_TX_STOP_BIT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d    = '0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = s_CLEANUP;
                end
            end

            s_CLEANUP: begin
                serial_d = 1'b1;
                state_d  = s_IDLE;
            end

            default: begin
                serial_d = 1'b1;
                active_d = 1'b0;
                cnt_d    = '0;
                state_d  = s_IDLE;
            end
        endcase
    end

    assign o_Tx_Ready  = fifo_rdy;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Tx_Ovf    = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed writes push expected bytes; a line monitor
// decodes every frame off o_Tx_Serial and compares it against the queue.
module tb_uart_tx_buf;

    localparam int CPB   = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       dv      = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       rdy;
    logic       ser;
    logic       act;
    logic       done;
    logic       ovf;

    int         checks   = 0;
    int         errors   = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    logic [7:0] exp_q[$];
    int         start_cyc[$];

    uart_tx_buf #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Tx_DV     (dv),
        .i_Tx_Byte   (byte_in),
        .o_Tx_Ready  (rdy),
        .o_Tx_Serial (ser),
        .o_Tx_Active (act),
        .o_Tx_Done   (done),
        .o_Tx_Ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- line monitor / scoreboard ----------------
    logic smp [FRAME];
    int   m_idx       = 0;
    bit   m_busy      = 1'b0;
    bit   m_act_ok    = 1'b1;
    bit   m_done_next = 1'b0;

    task automatic check_frame();
        logic [7:0] got;
        bit         shape_ok;
        shape_ok = 1'b1;
        got      = 8'h00;
        for (int i = 0; i < CPB; i++) begin
            if (smp[i] !== 1'b0) shape_ok = 1'b0;
            if (smp[9*CPB + i] !== 1'b1) shape_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) begin
            got[b] = smp[(b+1)*CPB];
            for (int i = 1; i < CPB; i++) begin
                if (smp[(b+1)*CPB + i] !== got[b]) shape_ok = 1'b0;
            end
        end
        chk("frame_shape", {31'd0, shape_ok}, 32'd1);
        chk("frame_active_no_done", {31'd0, m_act_ok}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", got);
        end else begin
            chk("frame_byte", {24'd0, got}, {24'd0, exp_q.pop_front()});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy      = 1'b0;
            m_idx       = 0;
            m_done_next = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (m_done_next) begin
                chk("done_pulse", {31'd0, done}, 32'd1);
                chk("active_after_stop", {31'd0, act}, 32'd0);
                m_done_next = 1'b0;
            end
            if (!m_busy && ser === 1'b0) begin
                m_busy   = 1'b1;
                m_idx    = 0;
                m_act_ok = 1'b1;
                start_cyc.push_back(cyc);
            end
            if (m_busy) begin
                smp[m_idx] = ser;
                if (act !== 1'b1 || done !== 1'b0) m_act_ok = 1'b0;
                m_idx++;
                if (m_idx == FRAME) begin
                    m_busy      = 1'b0;
                    m_done_next = 1'b1;
                    check_frame();
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; leaves at the following posedge+1.
    task automatic wr(input logic [7:0] b, input bit exp_acc);
        dv      = 1'b1;
        byte_in = b;
        chk("ready_before_write", {31'd0, rdy}, {31'd0, exp_acc});
        @(posedge clk);
        #1;
        chk("ovf_after_write", {31'd0, ovf}, {31'd0, !exp_acc});
        if (exp_acc) exp_q.push_back(b);
        dv = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, done_cnt, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ns;
        int n;
        bit to;
        logic [7:0] b;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_serial", {31'd0, ser}, 32'd1);
        chk("rst_active", {31'd0, act}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf}, 32'd0);
        chk("rst_ready",  {31'd0, rdy}, 32'd1);

        // First write on the first edge after release, then start-bit latency
        rst_n = 1'b1;
        wr(8'hA5, 1'b1);
        chk("latency_pre", {31'd0, ser}, 32'd1);
        @(posedge clk);
        #1;
        chk("latency_start", {31'd0, ser}, 32'd0);
        chk("active_start",  {31'd0, act}, 32'd1);
        wait_frames(1, 200, "frames_a5");

        // Back-to-back frames: 80-cycle frame + 2 idle cycles
        ns = start_cyc.size();
        wr(8'h00, 1'b1);
        wr(8'hFF, 1'b1);
        wr(8'h55, 1'b1);
        wait_frames(4, 400, "frames_b2b");
        if (start_cyc.size() >= ns + 3) begin
            chk("gap_0_1", start_cyc[ns+1] - start_cyc[ns], FRAME + 2);
            chk("gap_1_2", start_cyc[ns+2] - start_cyc[ns+1], FRAME + 2);
        end else begin
            chk("b2b_frame_count", start_cyc.size(), ns + 3);
        end

        // Burst of 6: one popped, four buffered, sixth overflows
        wr(8'h10, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h12, 1'b1);
        wr(8'h13, 1'b1);
        wr(8'h14, 1'b1);
        wr(8'h15, 1'b0);
        @(posedge clk);
        #1;
        chk("ovf_one_cycle", {31'd0, ovf}, 32'd0);
        wait_frames(9, 5*(FRAME+2) + 100, "frames_burst");

        // Write coinciding with a pop at occupancy DEPTH-1
        wr(8'h20, 1'b1);
        wr(8'h21, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h23, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_done_c0", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        wr(8'h24, 1'b1);
        wr(8'h25, 1'b1);
        chk("ready_full_after", {31'd0, rdy}, 32'd0);
        wait_frames(15, 6*(FRAME+2) + 100, "frames_pop_write");

        // Reset during data bit 3 of 0x3C
        wr(8'h3C, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        repeat (33) @(posedge clk);
        #3;
        chk("bit3_active", {31'd0, act}, 32'd1);
        chk("bit3_value",  {31'd0, ser}, 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        base = done_cnt;
        #1;
        chk("midrst_serial", {31'd0, ser}, 32'd1);
        chk("midrst_active", {31'd0, act}, 32'd0);
        chk("midrst_done",   {31'd0, done}, 32'd0);
        chk("midrst_ready",  {31'd0, rdy}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (150) @(posedge clk);
        #1;
        chk("postrst_no_done", done_cnt, base);
        chk("postrst_serial",  {31'd0, ser}, 32'd1);
        chk("postrst_ready",   {31'd0, rdy}, 32'd1);

        // 256 random bytes with ready/valid handshake
        to = 1'b0;
        for (int i = 0; i < 256 && !to; i++) begin
            b       = 8'($urandom_range(0, 255));
            dv      = 1'b1;
            byte_in = b;
            n       = 0;
            while (rdy !== 1'b1 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (rdy !== 1'b1) begin
                chk("ready_timeout", {31'd0, rdy}, 32'd1);
                to = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                exp_q.push_back(b);
            end
            dv = 1'b0;
        end
        wait_frames(base + 256, 256*(FRAME+2) + 500, "frames_random");
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
